// File: rtl/expr_pkg.sv
// Shared types and constants for the streaming expression checker.
// Defines the FSM state enum, the character-class enum and the ASCII codes the classifier decodes.
// Contains no logic, so it adds no latency and has no backpressure.
package expr_pkg;

  // Recogniser state: expecting an operand, expecting an operator, or failed.
  typedef enum logic [1:0] {
    S_OPND = 2'd0,
    S_OPER = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  // Lexical class of one input character.
  typedef enum logic [2:0] {
    CC_DIGIT = 3'd0,
    CC_OP    = 3'd1,
    CC_LPAR  = 3'd2,
    CC_RPAR  = 3'd3,
    CC_BAD   = 3'd4
  } cclass_e;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_LPAR  = 8'h28;
  localparam logic [7:0] ASCII_RPAR  = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Classifies one ASCII character as digit, operator, '(' , ')' or illegal.
// Purely combinational, zero latency; no flow control.
// Macro EXPR_EXT_OPS_EN adds '-' and '/' to the operator set.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch_i,
  output cclass_e    cls_o
);

`ifdef EXPR_EXT_OPS_EN
  localparam bit EXT_OPS = 1'b1;
`else
  localparam bit EXT_OPS = 1'b0;
`endif

  // Decode the character; anything not recognised (including whitespace) is illegal.
  always_comb begin
    cls_o = CC_BAD;
    if (ch_i >= ASCII_0 && ch_i <= ASCII_9) begin
      cls_o = CC_DIGIT;
    end else if (ch_i == ASCII_PLUS || ch_i == ASCII_STAR) begin
      cls_o = CC_OP;
    end else if (EXT_OPS && (ch_i == ASCII_MINUS || ch_i == ASCII_SLASH)) begin
      cls_o = CC_OP;
    end else if (ch_i == ASCII_LPAR) begin
      cls_o = CC_LPAR;
    end else if (ch_i == ASCII_RPAR) begin
      cls_o = CC_RPAR;
    end
  end

endmodule

// File: rtl/expr_stream_checker.sv
// Streaming recogniser: flags whether the characters consumed so far form a complete legal expression.
// One character per cycle with in_valid=1; outputs are register decodes, 1-cycle latency.
// No backpressure: in_valid=0 simply holds state; optional EXPR_EXT_OPS_EN enables '-' and '/'.
module expr_stream_checker
  import expr_pkg::*;
#(
  parameter int MAX_DEPTH   = 4,
  parameter int MULTI_DIGIT = 0,
  parameter int DEPTH_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam bit                 MULTI     = (MULTI_DIGIT != 0);

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  cclass_e            cls;

  expr_char_class u_class (
    .ch_i  (in),
    .cls_o (cls)
  );

  // State and nesting-depth registers; clr overrides any character on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_OPND;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

  // Next-state logic; depth only moves on legal parentheses, so it freezes on error entry and never wraps.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    if (in_valid) begin
      unique case (state_q)
        S_OPND: begin
          if (cls == CC_DIGIT) begin
            state_d = S_OPER;
          end else if (cls == CC_LPAR && depth_q != DEPTH_MAX) begin
            depth_d = depth_q + DEPTH_ONE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_OPER: begin
          if (cls == CC_OP) begin
            state_d = S_OPND;
          end else if (cls == CC_RPAR && depth_q != '0) begin
            depth_d = depth_q - DEPTH_ONE;
          end else if (cls == CC_DIGIT && MULTI) begin
            state_d = S_OPER;
          end else begin
            state_d = S_ERR;
          end
        end
        default: begin
          state_d = S_ERR;
        end
      endcase
    end
  end

  // Output decode from registers only.
  always_comb begin
    out   = (state_q == S_OPER) && (depth_q == '0);
    err   = (state_q == S_ERR);
    depth = depth_q;
  end

endmodule

// File: tb/tb_expr_stream_checker.sv
module tb_expr_stream_checker;

`ifdef EXPR_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_c = 8'h20;

  logic       out_a, err_a;
  logic [2:0] depth_a;
  logic       out_b, err_b;
  logic [1:0] depth_b;

  int tests = 0;
  int fails = 0;

  byte hist[$];

  always #50 clk = ~clk;

  // A: defaults (depth 4, single digit). B: depth 2, multi-digit operands.
  expr_stream_checker #(.MAX_DEPTH(4), .MULTI_DIGIT(0)) dut_a (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_c),
    .out(out_a), .err(err_a), .depth(depth_a)
  );

  expr_stream_checker #(.MAX_DEPTH(2), .MULTI_DIGIT(1)) dut_b (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_c),
    .out(out_b), .err(err_b), .depth(depth_b)
  );

  // Reference: scan the whole accepted string with the grammar's rules.
  function automatic void ref_eval(input byte h[$], input int maxd, input bit multi,
                                   output bit o, output bit e, output int d);
    int  bal;
    bit  want_operand;
    bit  is_dig, is_op;
    byte c;
    bal = 0;
    want_operand = 1'b1;
    e = 1'b0;
    for (int i = 0; i < h.size(); i++) begin
      c = h[i];
      is_dig = (c >= "0") && (c <= "9");
      is_op  = (c == "+") || (c == "*") || (EXT && ((c == "-") || (c == "/")));
      if (want_operand) begin
        if (is_dig) want_operand = 1'b0;
        else if (c == "(" && bal < maxd) bal = bal + 1;
        else e = 1'b1;
      end else begin
        if (is_op) want_operand = 1'b1;
        else if (c == ")" && bal > 0) bal = bal - 1;
        else if (is_dig && multi) want_operand = 1'b0;
        else e = 1'b1;
      end
      if (e) break;
    end
    o = !e && !want_operand && (bal == 0);
    d = bal;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    bit o, e;
    int d;
    ref_eval(hist, 4, 1'b0, o, e, d);
    chk({tag, ".a.out"},   int'(out_a),   int'(o));
    chk({tag, ".a.err"},   int'(err_a),   int'(e));
    chk({tag, ".a.depth"}, int'(depth_a), d);
    ref_eval(hist, 2, 1'b1, o, e, d);
    chk({tag, ".b.out"},   int'(out_b),   int'(o));
    chk({tag, ".b.err"},   int'(err_b),   int'(e));
    chk({tag, ".b.depth"}, int'(depth_b), d);
  endtask

  // Apply one cycle at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input byte c, input bit v, input bit r);
    @(negedge clk);
    in_c = c;
    in_valid = v;
    clr = r;
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else if (v) hist.push_back(c);
    clr = 1'b0;
    check_all($sformatf("step'%c'v%0d", c, v));
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0);
  endtask

  task automatic do_clr();
    step("+", 1'b1, 1'b1);
  endtask

  initial begin
    string alpha;
    byte   c;
    int    r;

    // Reset state
    do_clr();
    chk("reset.out", int'(out_a), 0);
    chk("reset.err", int'(err_a), 0);
    chk("reset.depth", int'(depth_a), 0);

    // Nested expression
    feed("(1+2+3+3*1)");
    chk("paren_expr.out", int'(out_a), 1);
    chk("paren_expr.depth", int'(depth_a), 0);

    // Operator after operator is sticky error
    do_clr();
    feed("1+*5");
    chk("sticky.err", int'(err_a), 1);
    chk("sticky.out", int'(out_a), 0);

    // Overflow on B (depth 2), underflow from reset
    do_clr();
    feed("(((");
    chk("overflow.b.err", int'(err_b), 1);
    chk("overflow.b.depth", int'(depth_b), 2);
    chk("overflow.a.depth", int'(depth_a), 3);
    do_clr();
    feed(")");
    chk("underflow.err", int'(err_a), 1);

    // Multi-digit difference
    do_clr();
    feed("12");
    chk("twodigit.a.err", int'(err_a), 1);
    chk("twodigit.b.out", int'(out_b), 1);
    do_clr();
    feed("()");

    // Held input with in_valid low
    do_clr();
    feed("7");
    for (int i = 0; i < 3; i++) step("+", 1'b0, 1'b0);
    chk("hold.out", int'(out_a), 1);

    // clr mid-expression
    do_clr();
    feed("(3+");
    do_clr();
    chk("midclr.depth", int'(depth_a), 0);
    feed("4");
    chk("midclr.out", int'(out_a), 1);

    // Extended ops
    do_clr();
    feed("9-3");
    if (EXT) chk("extop.out", int'(out_a), 1);
    else     chk("extop.err", int'(err_a), 1);

    // Illegal whitespace, deep nesting, ')' after operator
    do_clr();
    feed("(((2)))*1");
    do_clr();
    feed("1 ");
    do_clr();
    feed("((4+)");

    // Randomized stream
    alpha = "0123456789+*+*-/(()) x";
    do_clr();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, alpha.len() - 1);
      c = alpha[r];
      step(c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
